// File: rtl/encoder_sched_if.sv
// Handshake and config bundle for encoder_sched.
// master drives samples, out_ready and config; slave is the sequencer.
interface encoder_sched_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_sample;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] feature0;
  logic signed [7:0] feature1;
  logic [31:0]       hidden_flat;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic signed [7:0] cfg_data;
  logic              cfg_ready;
  logic              busy;

  modport master (
    output in_valid, in_sample, out_ready,
    output cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid,
    input  feature0, feature1, hidden_flat,
    input  cfg_ready, busy
  );

  modport slave (
    input  in_valid, in_sample, out_ready,
    input  cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid,
    output feature0, feature1, hidden_flat,
    output cfg_ready, busy
  );
endinterface

// File: rtl/encoder_sched.sv
// Encoder sequencer: one shared 8-bit MAC for 4 L1 + 2 L2 neurons.
// Ports: clk, rst_n (sync, active-low), bus (encoder_sched_if.slave).
// ENC_RELU_EN selects ReLU activation; default is identity.
module encoder_sched #(
  parameter int FRAC = 6
) (
  input logic           clk,
  input logic           rst_n,
  encoder_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, L1, L2, OUT
  } state_t;

  state_t state, state_n;

  logic [1:0]        idx;
  logic signed [7:0] x;
  logic signed [7:0] w1 [4];
  logic signed [7:0] b1 [4];
  logic signed [7:0] w2 [2];
  logic signed [7:0] b2 [2];
  logic signed [7:0] h  [4];
  logic signed [7:0] f  [2];

  logic signed [7:0]  op_a, op_w, op_b;
  logic signed [15:0] prod, shr;
  logic signed [16:0] sum;
  logic signed [7:0]  sat, y;
  logic               idle, ovld, cfg_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    idle    = 1'b0;
    ovld    = 1'b0;
    unique case (state)
      IDLE: begin
        idle = 1'b1;
        if (bus.in_valid) state_n = L1;
      end
      L1: if (idx == 2'd3) state_n = L2;
      L2: if (idx == 2'd1) state_n = OUT;
      OUT: begin
        ovld = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign cfg_wr = bus.cfg_we && idle;

  // Operand select for the single shared neuron.
  always_comb begin
    op_a = x;
    op_w = w1[idx];
    op_b = b1[idx];
    if (state == L2) begin
      op_a = h[idx[0]];
      op_w = w2[idx[0]];
      op_b = b2[idx[0]];
    end
  end

  assign prod = 16'(op_a) * 16'(op_w);
  assign shr  = prod >>> FRAC;
  assign sum  = {shr[15], shr}
              + {{9{op_b[7]}}, op_b};

  always_comb begin
    if (sum > 17'sd127)
      sat = 8'sd127;
    else if (sum < -17'sd128)
      sat = 8'h80;
    else
      sat = sum[7:0];
  end

`ifdef ENC_RELU_EN
  assign y = sat[7] ? 8'sd0 : sat;
`else
  assign y = sat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      x   <= '0;
      for (int i = 0; i < 4; i++) begin
        w1[i] <= '0;
        b1[i] <= '0;
        h[i]  <= '0;
      end
      for (int j = 0; j < 2; j++) begin
        w2[j] <= '0;
        b2[j] <= '0;
        f[j]  <= '0;
      end
    end else begin
      if (cfg_wr) begin
        unique case (1'b1)
          bus.cfg_addr[3:2] == 2'b00:
            w1[bus.cfg_addr[1:0]] <= bus.cfg_data;
          bus.cfg_addr[3:2] == 2'b01:
            b1[bus.cfg_addr[1:0]] <= bus.cfg_data;
          bus.cfg_addr[3:1] == 3'b100:
            w2[bus.cfg_addr[0]] <= bus.cfg_data;
          bus.cfg_addr[3:1] == 3'b101:
            b2[bus.cfg_addr[0]] <= bus.cfg_data;
          default: ;
        endcase
      end
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x   <= bus.in_sample;
            idx <= '0;
          end
        end
        L1: begin
          h[idx] <= y;
          idx    <= idx + 2'd1;
        end
        L2: begin
          f[idx[0]] <= y;
          idx       <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = idle;
  assign bus.cfg_ready   = idle;
  assign bus.out_valid   = ovld;
  assign bus.busy        = !idle;
  assign bus.feature0    = f[0];
  assign bus.feature1    = f[1];
  assign bus.hidden_flat = {h[3], h[2], h[1], h[0]};

endmodule

// File: tb/tb_encoder_sched.sv
// Directed self-checking bench for encoder_sched.
// Drives and samples on the falling edge.
module tb_encoder_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  encoder_sched_if bus ();

  encoder_sched #(.FRAC(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic cfg_write(input logic [3:0] a,
                           input logic [7:0] d);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_sample(input logic [7:0] s,
                           output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_sample = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_cfg_ready: got %b want 1", bus.cfg_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", bus.busy);
    end
    checks++;
    if ({bus.feature1, bus.feature0} !== 16'h0) begin
      errors++;
      $display("FAIL rst_features: got %h want 0",
               {bus.feature1, bus.feature0});
    end
    checks++;
    if (bus.hidden_flat !== 32'h0) begin
      errors++;
      $display("FAIL rst_hidden: got %h want 0", bus.hidden_flat);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    cfg_write(4'd0, 8'd64);
    cfg_write(4'd4, 8'd0);
    cfg_write(4'd8, 8'd64);
    cfg_write(4'd10, 8'd5);
    do_sample(8'd32, lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 7", lat);
    end
    checks++;
    if (bus.hidden_flat !== 32'h00000020) begin
      errors++;
      $display("FAIL basic_hidden: got %h want 00000020",
               bus.hidden_flat);
    end
    checks++;
    if (bus.feature0 !== 8'd37) begin
      errors++;
      $display("FAIL basic_f0: got %0d want 37", bus.feature0);
    end
    checks++;
    if (bus.feature1 !== 8'd0) begin
      errors++;
      $display("FAIL basic_f1: got %0d want 0", bus.feature1);
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_out_flags: got busy=%b cfg_ready=%b want 1 0",
               bus.busy, bus.cfg_ready);
    end
    consume();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: got ov=%b ir=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_saturate();
    int lat;
    cfg_write(4'd0, 8'd127);
    do_sample(8'd127, lat);
    checks++;
    if (bus.hidden_flat[7:0] !== 8'd127) begin
      errors++;
      $display("FAIL sat_h0: got %0d want 127", bus.hidden_flat[7:0]);
    end
    checks++;
    if (bus.feature0 !== 8'd127) begin
      errors++;
      $display("FAIL sat_f0: got %0d want 127", bus.feature0);
    end
    consume();
  endtask

  task automatic test_negative();
    int lat;
    logic [7:0] eh, ef;
`ifdef ENC_RELU_EN
    eh = 8'h00;
    ef = 8'h05;
`else
    eh = 8'hC0;
    ef = 8'hC5;
`endif
    cfg_write(4'd0, 8'd64);
    cfg_write(4'd4, 8'd0);
    do_sample(8'hC0, lat);
    checks++;
    if (bus.hidden_flat[7:0] !== eh) begin
      errors++;
      $display("FAIL neg_h0: got %h want %h", bus.hidden_flat[7:0], eh);
    end
    checks++;
    if (bus.feature0 !== ef) begin
      errors++;
      $display("FAIL neg_f0: got %h want %h", bus.feature0, ef);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    do_sample(8'd32, lat);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 4'd8;
    bus.cfg_data = 8'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.feature0 !== 8'd37 ||
          bus.in_ready !== 1'b0 ||
          bus.hidden_flat !== 32'h00000020) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%b f0=%0d ir=%b h=%h want 1 37 0 00000020",
                 i, bus.out_valid, bus.feature0, bus.in_ready,
                 bus.hidden_flat);
      end
    end
    bus.cfg_we = 1'b0;
    consume();
    do_sample(8'd32, lat);
    checks++;
    if (bus.feature0 !== 8'd37) begin
      errors++;
      $display("FAIL bp_cfg_dropped: got f0=%0d want 37", bus.feature0);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_sample = 8'd50;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got ir=%b busy=%b ov=%b want 1 0 0",
               bus.in_ready, bus.busy, bus.out_valid);
    end
    checks++;
    if (bus.hidden_flat !== 32'h0 ||
        {bus.feature1, bus.feature0} !== 16'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got h=%h f=%h want 0 0",
               bus.hidden_flat, {bus.feature1, bus.feature0});
    end
    rst_n = 1'b1;
    do_sample(8'd100, lat);
    checks++;
    if (lat !== 7 || bus.hidden_flat !== 32'h0 ||
        {bus.feature1, bus.feature0} !== 16'h0) begin
      errors++;
      $display("FAIL midrst_readback: got lat=%0d h=%h f=%h want 7 0 0",
               lat, bus.hidden_flat, {bus.feature1, bus.feature0});
    end
    consume();
  endtask

  task automatic test_cfg_same_cycle();
    int lat;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 8'd64;
    bus.in_valid = 1'b1;
    bus.in_sample = 8'd32;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 7 || bus.hidden_flat !== 32'h00000020) begin
      errors++;
      $display("FAIL same_cycle_cfg: got lat=%0d h=%h want 7 00000020",
               lat, bus.hidden_flat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  xs [3];
    logic [31:0] eh [3];
    logic [7:0]  e0 [3];
    logic [7:0]  e1 [3];
    int acc [3];
    int n;
    xs = '{8'd10, 8'd20, 8'd40};
    eh = '{32'h0000050A, 32'h00000A14, 32'h00001428};
    e0 = '{8'd10, 8'd20, 8'd40};
    e1 = '{8'd6, 8'd11, 8'd21};
    cfg_write(4'd1, 8'd32);
    cfg_write(4'd8, 8'd64);
    cfg_write(4'd9, 8'd64);
    cfg_write(4'd11, 8'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_sample = xs[k];
      n = 0;
      while (!bus.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      acc[k] = cyc;
      @(negedge clk);
      n = 0;
      while (!bus.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus.hidden_flat !== eh[k] || bus.feature0 !== e0[k] ||
          bus.feature1 !== e1[k]) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got h=%h f0=%0d f1=%0d want %h %0d %0d",
                 k, bus.hidden_flat, bus.feature0, bus.feature1,
                 eh[k], e0[k], e1[k]);
      end
      if (k == 2) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (acc[k] - acc[k-1] !== 8) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 8",
                 k, acc[k] - acc[k-1]);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_negative();
    test_backpressure();
    test_reset_mid();
    test_cfg_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_sched.md
# encoder_sched

Sequencer for the denoising-autoencoder encoder. It time-multiplexes one shared signed 8-bit MAC/activation unit across the encoder's four layer-1 neurons and two layer-2 neurons for each input audio sample. It holds the trained weights and biases in a small register file loaded through a configuration port. It sits between the sample stream from the ADC front end and the decoder, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `FRAC`, 6: fractional bits of weights (Q1.6); the product is arithmetic-shifted right by `FRAC`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  block can accept a sample
- `in_sample`  in  8  signed input sample
- `out_valid`  out  1  features valid
- `out_ready`  in  1  downstream accepts features
- `feature0`, `feature1`  out  8 each  signed compressed features
- `hidden_flat`  out  32  layer-1 outputs `{h3,h2,h1,h0}`, signed 8-bit each
- `cfg_we`  in  1  parameter write strobe
- `cfg_addr`  in  4  parameter address
- `cfg_data`  in  8  signed parameter value
- `cfg_ready`  out  1  high when writes are accepted
- `busy`  out  1  high in any state except IDLE

## Operation
- Register map:
  - 0–3: `w1_0`..`w1_3`
  - 4–7: `b1_0`..`b1_3`
  - 8–9: `w2_0`, `w2_1`
  - 10–11: `b2_0`, `b2_1`
  - 12–15: ignored
- All parameters reset to 0.
- Config writes:
  - Take effect only when `cfg_we && cfg_ready`.
  - `cfg_ready` equals (state == IDLE). Writes in any other state are dropped, with no queueing.
- Neuron function: `y = act(sat8(((a*w) >>> FRAC) + b))`.
  - `a*w` is a 16-bit signed product.
  - `b` is sign-extended to 17 bits before the add.
  - `sat8` clamps to [-128, 127].
- Layer 1: `h_i = neuron(x, w1_i, b1_i)` for i = 0..3, where `x` is the latched sample.
- Layer 2: `f_j = neuron(h_j, w2_j, b2_j)` for j = 0..1.
- Exactly one neuron is evaluated per cycle on the single shared multiplier.
- State machine:
  - IDLE: `in_ready`=1. On `in_valid`, latch `x`, clear `idx`, go to L1.
  - L1: compute `h[idx]`, `idx`++. After idx 3, clear `idx` and go to L2.
  - L2: compute `f[idx]`, `idx`++. After idx 1, go to OUT.
  - OUT: `out_valid`=1. On `out_ready`, go to IDLE.
- `feature0`, `feature1` and `hidden_flat` are registered and stable from OUT entry until the next L1 overwrites them.
- Reset mid-operation: the next cycle is in IDLE with all outputs at reset values. The in-flight sample is discarded and parameters return to 0.

## Timing
- Reset values:
  - `in_ready`=1, `cfg_ready`=1
  - `out_valid`=0, `busy`=0
  - `feature0`=0, `feature1`=0, `hidden_flat`=0
- Accept at edge T (IDLE, `in_valid`=1): L1 occupies T+1..T+4, L2 occupies T+5..T+6, and `out_valid`=1 from T+7.
- Latency: 7 cycles from accept to `out_valid`.
- Throughput: one sample per 8 cycles with `out_ready` held high (the OUT→IDLE cycle is not overlapped).
- `in_ready` is combinational from state only and is never dependent on `in_valid`.
- `out_valid` stays high until `out_ready` is sampled high, so backpressure stalls indefinitely.
- Simultaneous `cfg_we` and `in_valid` in IDLE:
  - The write commits.
  - The sample is also accepted, and L1 uses the newly written value.

## Configuration
- `ENC_RELU_EN` defined: `act` is ReLU, so any negative saturated result becomes 0.
- `ENC_RELU_EN` undefined: `act` is identity, so the saturated signed result passes through unchanged.

## Test plan
- Reset, then write `w1_0`=64, `b1_0`=0, `w2_0`=64, `b2_0`=5 and send `in_sample`=32 → `h0`=32 and `feature0`=37, with `out_valid` rising exactly 7 cycles after accept.
- Set `w1_0`=127 and send `in_sample`=127 (product 16129 >>> 6 = 252) → `h0`=127 (saturated).
- Set `w1_0`=64, `b1_0`=0 and send `in_sample`=-64 → `h0`=0 with `ENC_RELU_EN` defined, -64 without it.
- Hold `out_ready`=0 for 10 cycles in OUT → `out_valid` and features remain stable, `in_ready`=0, and a `cfg_we` to addr 8 is ignored (`w2_0` unchanged).
- Assert `rst_n`=0 at cycle T+3 of a computation → next cycle in IDLE, `out_valid`=0, all outputs 0, and a readback computation with all-zero parameters gives features 0.
- Back-to-back samples with `out_ready`=1 → accepts spaced exactly 8 cycles apart and all results correct.
